mem_bus_if: RTL and testbench
=============================

MEM_BUS_IF -- requirements
Module: mem_bus_if

Interface
REQ-001 Parameter ADDR_W, default 26, SHALL set the address width of ADDR and M_ADDR.
REQ-002 Parameter TIMEOUT, default 16, SHALL set the wait-cycle limit, used only when MEM_TIMEOUT_EN is defined.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RST  in  1  SHALL be the reset, asynchronous and active-low.
REQ-005 READ  in  1  SHALL be the level read strobe from the control unit.
REQ-006 WRITE  in  1  SHALL be the level write strobe from the control unit.
REQ-007 ADDR  in  ADDR_W  SHALL be the word address from the datapath.
REQ-008 WDATA  in  32  SHALL be the store data from the datapath.
REQ-009 RDATA  out  32  SHALL be the latched read data returned to the datapath.
REQ-010 BUSY  out  1  SHALL be high whenever the FSM is not IDLE.
REQ-011 DONE  out  1  SHALL be a one-cycle completion pulse.
REQ-012 ERR  out  1  SHALL be the sticky timeout flag.
REQ-013 M_REQ  out  1  SHALL be the memory request.
REQ-014 M_WE  out  1  SHALL mark the request as a write.
REQ-015 M_ADDR  out  ADDR_W  SHALL be the registered request address.
REQ-016 M_WDATA  out  32  SHALL be the registered write data.
REQ-017 M_RDATA  in  32  SHALL be the memory read data, valid when M_ACK is high.
REQ-018 M_ACK  in  1  SHALL be the memory acknowledge.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, REQ and RESP.
REQ-020 A request SHALL be accepted only on a 0->1 edge of READ or WRITE (previous-cycle sampled value low) while in IDLE; a held level SHALL NOT re-issue.
REQ-021 On acceptance, the block SHALL register ADDR, WDATA and the write flag, and SHALL enter REQ on the next edge; M_REQ is high in REQ.
REQ-022 If READ and WRITE rise in the same cycle, WRITE SHALL win and M_WE=1.
REQ-023 Edges of READ or WRITE while BUSY SHALL be ignored and not queued.
REQ-024 In REQ, M_REQ, M_WE, M_ADDR and M_WDATA SHALL be held stable until M_ACK is sampled high.
REQ-025 When M_ACK is sampled high in REQ, the FSM SHALL go to RESP; on a read, RDATA SHALL load M_RDATA at that same edge.
REQ-026 In RESP, DONE SHALL be high for exactly one cycle and M_REQ SHALL be low; the next state SHALL be IDLE.
REQ-027 RDATA SHALL be unchanged by writes, by timeouts and by M_ACK seen outside REQ.
REQ-028 Minimum latency SHALL be 3 cycles from the accepting edge to the DONE pulse (M_ACK arriving in the first REQ cycle).
REQ-029 M_ACK asserted in IDLE or RESP SHALL be ignored.

Reset
REQ-030 RST low SHALL asynchronously force IDLE, including mid-transaction.
REQ-031 RST low SHALL asynchronously clear M_REQ, M_WE, DONE, BUSY and ERR.
REQ-032 RST low SHALL asynchronously clear RDATA, M_ADDR, M_WDATA and the edge-detect registers to 0.
REQ-033 After reset releases, a READ or WRITE already high SHALL NOT be accepted until it has been seen low.

Configuration
REQ-034 With MEM_TIMEOUT_EN defined, a wait counter SHALL clear on entry to REQ and increment each REQ cycle without M_ACK.
REQ-035 With MEM_TIMEOUT_EN defined, when the count reaches TIMEOUT, the FSM SHALL go to RESP, pulse DONE and set ERR.
REQ-036 With MEM_TIMEOUT_EN defined, ERR SHALL stay set until the next accepted request or reset.
REQ-037 With MEM_TIMEOUT_EN defined, M_ACK and timeout coinciding in the same cycle SHALL count as success, with ERR not set.
REQ-038 Without MEM_TIMEOUT_EN, the counter SHALL be absent, REQ SHALL wait indefinitely and ERR SHALL be tied 0.

Verification
REQ-039 The bench SHALL check a read: READ rises, ADDR=0x0000010, M_ACK after 2 REQ cycles with M_RDATA=0xDEADBEEF -> RDATA=0xDEADBEEF, one DONE pulse, BUSY for 4 cycles.
REQ-040 The bench SHALL check a write: WRITE rises, ADDR=0x3FFFFFF, WDATA=0x12345678, immediate M_ACK -> M_WE=1 with both values on M_*, RDATA unchanged, DONE 3 cycles after acceptance.
REQ-041 The bench SHALL check level hold: READ held high 10 cycles -> exactly one M_REQ transaction, one DONE pulse.
REQ-042 The bench SHALL check simultaneous READ and WRITE rising -> M_WE=1 and a write transaction.
REQ-043 The bench SHALL check reset mid-REQ: RST low in REQ -> M_REQ, BUSY = 0 immediately; no DONE pulse after release.
REQ-044 The bench SHALL check the timeout path: with MEM_TIMEOUT_EN and TIMEOUT=16, no M_ACK -> DONE and ERR after 16 REQ cycles, ERR cleared by the next accepted READ.

Source files
------------

// File: rtl/mem_bus_if_if.sv
// Bundles the control-unit and memory-side signals of mem_bus_if.
// The slave modport is the bridge's view. The master modport is the view of the
// environment that drives the strobes and answers the memory requests.
interface mem_bus_if_if #(
  parameter int ADDR_W = 26
) ();
  // control-unit side
  logic              i_read;
  logic              i_write;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_wdata;
  logic [31:0]       o_rdata;
  logic              o_busy;
  logic              o_done;
  logic              o_err;
  // memory side
  logic              o_m_req;
  logic              o_m_we;
  logic [ADDR_W-1:0] o_m_addr;
  logic [31:0]       o_m_wdata;
  logic [31:0]       i_m_rdata;
  logic              i_m_ack;

  modport slave (
    input  i_read, i_write, i_addr, i_wdata, i_m_rdata, i_m_ack,
    output o_rdata, o_busy, o_done, o_err, o_m_req, o_m_we, o_m_addr, o_m_wdata
  );

  modport master (
    output i_read, i_write, i_addr, i_wdata, i_m_rdata, i_m_ack,
    input  o_rdata, o_busy, o_done, o_err, o_m_req, o_m_we, o_m_addr, o_m_wdata
  );
endinterface

// File: rtl/mem_bus_if.sv
// Memory bus bridge: turns rising edges of the control unit's level READ/WRITE
// strobes into single request/acknowledge transactions on the memory side.
// Optional feature macro: MEM_TIMEOUT_EN. When it is defined, a request left
// unanswered for TIMEOUT cycles completes with the sticky ERR flag set.
// When it is undefined, REQ waits indefinitely and ERR is tied low.
module mem_bus_if #(
  parameter int ADDR_W  = 26,
  parameter int TIMEOUT = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  mem_bus_if_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_read_d;
  logic              r_write_d;
  logic              r_read_arm;
  logic              r_write_arm;
  logic              r_start;
  logic              r_busy;
  logic              r_done;
  logic              r_m_req;
  logic              r_m_we;
  logic [ADDR_W-1:0] r_m_addr;
  logic [31:0]       r_m_wdata;
  logic [31:0]       r_rdata;

  logic              w_read_rise;
  logic              w_write_rise;
  logic              w_accept;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_err;
  logic              w_timeout;

  // The counter holds the number of REQ cycles already spent without M_ACK.
  // This is the last allowed cycle when the count equals TIMEOUT-1.
  assign w_timeout = (r_wait_cnt == CNT_W'(TIMEOUT - 1));
  assign bus.o_err = r_err;
`else
  assign bus.o_err = 1'b0;
`endif

  // A strobe counts only after it has been seen low since reset ("arm").
  // A level that is already high when reset releases therefore cannot start a
  // transaction until it has been seen low.
  assign w_read_rise  = bus.i_read  & ~r_read_d  & r_read_arm;
  assign w_write_rise = bus.i_write & ~r_write_d & r_write_arm;
  // Edges are consumed whether or not they are accepted. An edge that arrives
  // while a request is pending or busy is therefore dropped, not queued.
  assign w_accept     = (r_state == IDLE) & ~r_start & (w_read_rise | w_write_rise);

  assign bus.o_rdata   = r_rdata;
  assign bus.o_busy    = r_busy;
  assign bus.o_done    = r_done;
  assign bus.o_m_req   = r_m_req;
  assign bus.o_m_we    = r_m_we;
  assign bus.o_m_addr  = r_m_addr;
  assign bus.o_m_wdata = r_m_wdata;

  // Sample the strobes every cycle for edge detection and arm them once they are seen low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_read_d    <= 1'b0;
      r_write_d   <= 1'b0;
      r_read_arm  <= 1'b0;
      r_write_arm <= 1'b0;
    end else begin
      r_read_d    <= bus.i_read;
      r_write_d   <= bus.i_write;
      r_read_arm  <= r_read_arm  | ~bus.i_read;
      r_write_arm <= r_write_arm | ~bus.i_write;
    end
  end

  // Transaction FSM with registered bus outputs. The accepting edge captures
  // the address, data and direction. The following edge enters REQ.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_m_req    <= 1'b0;
      r_m_we     <= 1'b0;
      r_m_addr   <= '0;
      r_m_wdata  <= '0;
      r_rdata    <= '0;
`ifdef MEM_TIMEOUT_EN
      r_wait_cnt <= '0;
      r_err      <= 1'b0;
`endif
    end else begin
      r_start <= w_accept;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_m_addr  <= bus.i_addr;
            r_m_wdata <= bus.i_wdata;
            // WRITE wins when both strobes rise together
            r_m_we    <= w_write_rise;
`ifdef MEM_TIMEOUT_EN
            r_err     <= 1'b0;
`endif
          end
          if (r_start) begin
            r_state <= REQ;
            r_m_req <= 1'b1;
            r_busy  <= 1'b1;
`ifdef MEM_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
          end
        end
        REQ: begin
          // M_ACK takes priority over a timeout in the same cycle
          if (bus.i_m_ack) begin
            r_state <= RESP;
            r_m_req <= 1'b0;
            r_done  <= 1'b1;
            if (!r_m_we) begin
              r_rdata <= bus.i_m_rdata;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (w_timeout) begin
            r_state <= RESP;
            r_m_req <= 1'b0;
            r_done  <= 1'b1;
            r_err   <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
          end
`endif
        end
        RESP: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_m_req <= 1'b0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_if.sv
// Directed, self-checking bench for mem_bus_if. Expected memory requests are
// queued when the stimulus is driven. Each queued entry is popped and compared
// when the DUT raises M_REQ. The bench follows the MEM_TIMEOUT_EN macro.
module tb_mem_bus_if;

  logic clk;
  logic rst_n;

  mem_bus_if_if #(.ADDR_W(26)) bus ();

  mem_bus_if #(
    .ADDR_W  (26),
    .TIMEOUT (16)
  ) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic        we;
    logic [25:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;

  int   n_chk;
  int   n_err;
  int   n_busy;
  int   n_done;
  int   n_req;
  logic prev_req;
  logic err_at_accept;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle. The DUT is sampled at the falling edge, and the
  // scoreboard and the event counters are updated there.
  task automatic tick();
    @(negedge clk);
    if (bus.o_done) n_done++;
    if (bus.o_busy) n_busy++;
    if (bus.o_m_req && !prev_req) begin
      n_req++;
      if (exp_q.size() == 0) begin
        chk("unexpected_req", 1, 0);
      end else begin
        cur = exp_q.pop_front();
        chk("m_we", bus.o_m_we, cur.we);
        chk("m_addr", bus.o_m_addr, cur.addr);
        chk("m_wdata", bus.o_m_wdata, cur.wdata);
      end
    end else if (bus.o_m_req && prev_req) begin
      chk("m_addr_hold", bus.o_m_addr, cur.addr);
      chk("m_we_hold", bus.o_m_we, cur.we);
    end
    if (bus.o_done) chk("rdata_at_done", bus.o_rdata, cur.rdata);
    prev_req = bus.o_m_req;
  endtask

  task automatic idle(input int n);
    bus.i_read  = 1'b0;
    bus.i_write = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drive one request and answer it with M_ACK in REQ cycle d+1 (d<0: never).
  // exp_lat is the number of cycles from the accepting cycle to the DONE cycle.
  task automatic txn(input string name, input logic rd, input logic wr,
                     input logic [25:0] a, input logic [31:0] wd, input int d,
                     input logic [31:0] mrd, input logic ewe, input logic [31:0] erd,
                     input int exp_lat, input int ncyc, input bit poke);
    exp_t e;
    int   lat;
    int   req0;
    e.we = ewe; e.addr = a; e.wdata = wd; e.rdata = erd;
    exp_q.push_back(e);
    n_busy = 0; n_done = 0; req0 = n_req; lat = 0;
    bus.i_read = rd; bus.i_write = wr; bus.i_addr = a; bus.i_wdata = wd;
    for (int c = 1; c <= ncyc; c++) begin
      tick();
      if (bus.o_done && lat == 0) lat = c;
      if (c == 1) begin
        chk({name, "_pending_busy"}, bus.o_busy, 1'b0);
        err_at_accept = bus.o_err;
      end
      if (poke && c == 2) bus.i_write = 1'b1;
      bus.i_m_ack   = (d >= 0 && c == 2 + d);
      bus.i_m_rdata = (d >= 0 && c == 2 + d) ? mrd : 32'h0BAD0BAD;
    end
    bus.i_m_ack = 1'b0;
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_done_pulses"}, n_done, 1);
    chk({name, "_busy_cycles"}, n_busy, exp_lat - 1);
    chk({name, "_req_count"}, n_req - req0, 1);
    chk({name, "_rdata"}, bus.o_rdata, erd);
  endtask

  initial begin
    n_chk = 0; n_err = 0; n_busy = 0; n_done = 0; n_req = 0;
    prev_req = 1'b0; err_at_accept = 1'b0;
    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.i_write = 1'b0; bus.i_addr = '0; bus.i_wdata = '0;
    bus.i_m_rdata = '0; bus.i_m_ack = 1'b0;
    tick(); tick();

    // reset state
    chk("rst_busy", bus.o_busy, 0);
    chk("rst_done", bus.o_done, 0);
    chk("rst_err", bus.o_err, 0);
    chk("rst_m_req", bus.o_m_req, 0);
    chk("rst_m_we", bus.o_m_we, 0);
    chk("rst_rdata", bus.o_rdata, 0);
    chk("rst_m_addr", bus.o_m_addr, 0);
    chk("rst_m_wdata", bus.o_m_wdata, 0);
    rst_n = 1'b1;
    idle(2);

    // M_ACK while idle is ignored
    n_done = 0; n_busy = 0;
    bus.i_m_ack = 1'b1; bus.i_m_rdata = 32'h55555555;
    tick(); tick();
    bus.i_m_ack = 1'b0;
    chk("idle_ack_rdata", bus.o_rdata, 0);
    chk("idle_ack_done", n_done, 0);
    chk("idle_ack_busy", n_busy, 0);

    // read with M_ACK after two REQ cycles
    txn("read", 1, 0, 26'h0000010, 32'hA5A5A5A5, 2, 32'hDEADBEEF, 0, 32'hDEADBEEF, 5, 7, 0);
    idle(2);

    // write at the top address with an immediate ack: RDATA must not change
    txn("write", 0, 1, 26'h3FFFFFF, 32'h12345678, 0, 32'h77777777, 1, 32'hDEADBEEF, 3, 5, 0);
    idle(2);

    // READ held high for 10 cycles gives a single transaction
    txn("level_hold", 1, 0, 26'h0000ABC, 32'h0, 0, 32'hCAFEF00D, 0, 32'hCAFEF00D, 3, 10, 0);
    idle(2);

    // READ and WRITE rising together become a write
    txn("simul", 1, 1, 26'h1234567, 32'h9ABCDEF0, 1, 32'h66666666, 1, 32'hCAFEF00D, 4, 6, 0);
    idle(2);

    // WRITE rising while busy is dropped, not queued
    txn("busy_edge", 1, 0, 26'h0000020, 32'h0, 1, 32'h01234567, 0, 32'h01234567, 4, 6, 1);
    n_done = 0;
    idle(4);
    chk("busy_edge_no_replay", n_done, 0);

`ifdef MEM_TIMEOUT_EN
    // no M_ACK: the request times out after 16 REQ cycles and ERR is set
    txn("timeout", 1, 0, 26'h0000040, 32'h0, -1, 32'h0, 0, 32'h01234567, 18, 20, 0);
    chk("timeout_err", bus.o_err, 1);
    idle(3);
    chk("timeout_err_sticky", bus.o_err, 1);
    txn("after_timeout", 1, 0, 26'h0000044, 32'h0, 0, 32'h76543210, 0, 32'h76543210, 3, 5, 0);
    chk("err_cleared_on_accept", err_at_accept, 0);
    chk("err_after_success", bus.o_err, 0);
    idle(2);
    // M_ACK arriving in the same cycle as the timeout counts as success
    txn("ack_at_limit", 1, 0, 26'h0000048, 32'h0, 15, 32'h0F0F0F0F, 0, 32'h0F0F0F0F, 18, 20, 0);
    chk("ack_at_limit_err", bus.o_err, 0);
    idle(2);
`else
    // without the timeout feature a request waits indefinitely for M_ACK
    txn("long_wait", 1, 0, 26'h0000040, 32'h0, 20, 32'h0F0F0F0F, 0, 32'h0F0F0F0F, 23, 25, 0);
    chk("long_wait_err", bus.o_err, 0);
    idle(2);
`endif

    // reset in the middle of REQ
    begin
      exp_t e;
      int   req0;
      e.we = 1'b0; e.addr = 26'h0000155; e.wdata = 32'h0; e.rdata = 32'h0;
      exp_q.push_back(e);
      bus.i_read = 1'b1; bus.i_addr = 26'h0000155; bus.i_wdata = 32'h0;
      tick(); tick();
      chk("midreq_m_req_before", bus.o_m_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midreq_m_req", bus.o_m_req, 0);
      chk("midreq_busy", bus.o_busy, 0);
      chk("midreq_rdata", bus.o_rdata, 0);
      chk("midreq_m_addr", bus.o_m_addr, 0);
      tick();
      rst_n = 1'b1;
      n_done = 0; req0 = n_req;
      for (int i = 0; i < 5; i++) tick();
      chk("midreq_no_done", n_done, 0);
      chk("midreq_held_read_ignored", n_req - req0, 0);
    end
    idle(2);

    // normal read after recovery
    txn("recover", 1, 0, 26'h0000200, 32'h0, 0, 32'h89ABCDEF, 0, 32'h89ABCDEF, 3, 5, 0);
    idle(2);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
